// File: rtl/serial_tx_if.sv
// Parallel-load handshake plus serial line of the frame transmitter.
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] Data_in;
  logic              Load;
  logic              Ready;
  logic              Busy;
  logic              Tx;

  modport master (output Data_in, output Load, input Ready, input Busy, input Tx);
  modport slave  (input Data_in, input Load, output Ready, output Busy, output Tx);
endinterface

// File: rtl/serial_tx.sv
// Serial frame transmitter: start / LSB-first data / optional even parity / stop,
// each bit held CLKS_PER_BIT cycles; all outputs registered.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input logic         Clock,
  input logic         Rst,
  serial_tx_if.slave  bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              cnt_last;

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = tx_q;
    ready_d  = ready_q;
    cnt_last = (cnt_q == CNT_LAST);

    if (state_q == IDLE) begin
      tx_d    = 1'b1;
      ready_d = 1'b1;
      cnt_d   = '0;
      // Accept edge drives the start bit directly, so it already counts as cycle 0.
      if (bus.Load && ready_q) begin
        shift_d = bus.Data_in;
        par_d   = ^bus.Data_in;
        tx_d    = 1'b0;
        ready_d = 1'b0;
        state_d = START;
      end
    end else if (!cnt_last) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
      unique case (state_q)
        START: begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          state_d = DATA;
        end
        DATA: begin
          if (bit_q == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
          end
        end
        PARITY: begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
        STOP: begin
          tx_d    = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = ~ready_d;
  end

  assign bus.Tx    = tx_q;
  assign bus.Ready = ready_q;
  assign bus.Busy  = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: default build plus a CLKS_PER_BIT=1, no-parity build.
module tb_serial_tx;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  serial_tx_if #(.DATA_W(8)) bus ();
  serial_tx_if #(.DATA_W(8)) bus6 ();

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut (
    .Clock (clk),
    .Rst   (rst),
    .bus   (bus)
  );

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_dut6 (
    .Clock (clk),
    .Rst   (rst),
    .bus   (bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered just after the accept edge; fr holds the frame bits, bit 0 sent first.
  task automatic frame_chk(input string tag, input logic [10:0] fr, input bit poke);
    for (int k = 0; k < 44; k++) begin
      chk({tag, "_tx"}, 32'(bus.Tx), 32'(fr[k / 4]));
      chk({tag, "_ready"}, 32'(bus.Ready), 32'd0);
      chk({tag, "_busy"}, 32'(bus.Busy), 32'd1);
      if (poke) begin
        if (k == 5)  begin bus.Load = 1'b1; bus.Data_in = 8'hFF; end
        if (k == 20) bus.Data_in = 8'h55;
        if (k == 42) bus.Load = 1'b0;
      end
      tick();
    end
    chk({tag, "_end_ready"}, 32'(bus.Ready), 32'd1);
    chk({tag, "_end_busy"}, 32'(bus.Busy), 32'd0);
    chk({tag, "_end_tx"}, 32'(bus.Tx), 32'd1);
  endtask

  logic [9:0] fr6;

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    bus.Load     = 1'b0;
    bus.Data_in  = '0;
    bus6.Load    = 1'b0;
    bus6.Data_in = '0;

    // 1: reset, then idle
    #2;
    chk("rst_tx", 32'(bus.Tx), 32'd1);
    chk("rst_ready", 32'(bus.Ready), 32'd1);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_tx", 32'(bus.Tx), 32'd1);
      chk("idle_ready", 32'(bus.Ready), 32'd1);
      chk("idle_busy", 32'(bus.Busy), 32'd0);
    end

    // 2: 0xA5, parity 0
    bus.Data_in = 8'hA5;
    bus.Load    = 1'b1;
    tick();
    bus.Load    = 1'b0;
    frame_chk("a5", {1'b1, 1'b0, 8'hA5, 1'b0}, 1'b0);
    tick();

    // 3: 0x07, parity 1, with ignored Load/Data_in changes mid-frame
    bus.Data_in = 8'h07;
    bus.Load    = 1'b1;
    tick();
    bus.Load    = 1'b0;
    frame_chk("h07", {1'b1, 1'b1, 8'h07, 1'b0}, 1'b1);
    tick();
    chk("h07_after_ready", 32'(bus.Ready), 32'd1);

    // 4: Load held high across two frames
    bus.Data_in = 8'h3C;
    bus.Load    = 1'b1;
    tick();
    bus.Data_in = 8'hC3;
    frame_chk("b2b1", {1'b1, 1'b0, 8'h3C, 1'b0}, 1'b0);
    tick();
    bus.Load = 1'b0;
    frame_chk("b2b2", {1'b1, 1'b0, 8'hC3, 1'b0}, 1'b0);
    tick();

    // 5: async reset during data bit 3 of 0x00
    bus.Data_in = 8'h00;
    bus.Load    = 1'b1;
    tick();
    bus.Load    = 1'b0;
    for (int k = 0; k < 17; k++) tick();
    chk("abort_pre_tx", 32'(bus.Tx), 32'd0);
    chk("abort_pre_busy", 32'(bus.Busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_tx", 32'(bus.Tx), 32'd1);
    chk("abort_ready", 32'(bus.Ready), 32'd1);
    chk("abort_busy", 32'(bus.Busy), 32'd0);
    #1;
    rst = 1'b0;
    tick();
    chk("abort_idle_tx", 32'(bus.Tx), 32'd1);
    chk("abort_idle_ready", 32'(bus.Ready), 32'd1);
    bus.Data_in = 8'h81;
    bus.Load    = 1'b1;
    tick();
    bus.Load    = 1'b0;
    frame_chk("h81", {1'b1, 1'b0, 8'h81, 1'b0}, 1'b0);
    tick();

    // 6: CLKS_PER_BIT=1, no parity
    fr6          = {1'b1, 8'h01, 1'b0};
    bus6.Data_in = 8'h01;
    bus6.Load    = 1'b1;
    tick();
    bus6.Load    = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("c1_tx", 32'(bus6.Tx), 32'(fr6[k]));
      chk("c1_ready", 32'(bus6.Ready), 32'd0);
      tick();
    end
    chk("c1_end_ready", 32'(bus6.Ready), 32'd1);
    chk("c1_end_busy", 32'(bus6.Busy), 32'd0);
    chk("c1_end_tx", 32'(bus6.Tx), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
